mbx_ahb_slave: RTL and testbench
================================

Name: mbx_ahb_slave

Overview:
AHB-Lite responder that terminates the CPU2 slave-9 mailbox path: it is the mailbox target that the slave-9 router forwards non-IOPMP traffic to. It exposes a memory-mapped TX queue (CPU2 to peer) and RX queue (peer to CPU2), with status and error responses. The peer side is a pair of valid/ready streams.

Parameters:
DEPTH, 4, entries per FIFO (power of 2, at least 2)
DW, 32, data width of the bus and the queues

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
hprot  in  4  AHB protection (ignored)
hsize  in  3  AHB transfer size
htrans  in  2  AHB transfer type
hwdata  in  32  write data (data phase)
hwrite  in  1  1=write
haddr  in  32  address (offset = haddr[7:0])
hrdata  out  32  read data
hready  out  1  transfer done / slave ready
hresp  out  2  00 OKAY, 01 ERROR
tx_data  out  32  TX queue head
tx_valid  out  1  TX queue not empty
tx_ready  in  1  peer pops TX head
rx_data  in  32  peer message
rx_valid  in  1  peer push request
rx_ready  out  1  RX queue not full
irq  out  1  RX-not-empty interrupt

Behaviour:
- Interface decided: one clock clk; reset is asynchronous and active-high.
- Reset values: hready=1, hresp=00, hrdata=0, tx_valid=0, rx_ready=1, irq=0, both FIFOs empty, irq_en=0, FSM=IDLE.
- Address phase is sampled when hready=1 and htrans[1]=1 (NONSEQ/SEQ). IDLE/BUSY get OKAY with zero wait states and cause no side effects.
- Register map (offset haddr[7:0]):
  - 0x00 TXDATA: W pushes hwdata; R returns 0.
  - 0x04 RXDATA: R pops the RX head; W is ignored (OKAY).
  - 0x08 STATUS: R only. [3:0] tx_count, [7:4] rx_count, [8] tx_full, [9] rx_empty, rest 0. Write is ignored.
  - 0x0C IRQ_EN: RW, bit0 only (see Optional Feature).
- Error conditions, decided at the address phase: hsize!=3'b010; unmapped offset; TXDATA write with tx_full; RXDATA read with rx_empty.
- ERROR response is two-cycle:
  - ERR1: hready=0, hresp=01.
  - ERR2: hready=1, hresp=01.
  - An erroring transfer has no FIFO side effect.
- FSM states: IDLE, DATA, RDWAIT, ERR1, ERR2.
  - IDLE/DATA + valid non-error transfer -> DATA. RXDATA read goes to RDWAIT instead.
  - Valid error transfer -> ERR1.
  - No transfer -> IDLE.
  - RDWAIT (hready=0) -> DATA. The RX head is registered into hrdata at that transition.
  - ERR1 -> ERR2. ERR2 samples a new address phase like IDLE.
- Latency:
  - Writes and non-RXDATA reads: zero wait states. Read data is valid in the first data-phase cycle.
  - RXDATA read: one wait state.
- TX push happens in the DATA cycle of a TXDATA write, using hwdata.
- Full/empty checks use counts at the address phase plus any push/pop pending in the current data phase.
- A same-cycle peer pop does not relieve full: back-to-back writes to a full queue with tx_ready=1 still return ERROR.
- TX queue: tx_valid=!tx_empty. A pop occurs when tx_valid and tx_ready.
- RX queue: rx_ready=!rx_full. A push occurs when rx_valid and rx_ready.
- Simultaneous push and pop on the same FIFO: count unchanged; data order preserved.
- Pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits; the STATUS field is zero-extended or truncated to 4 bits.
- hrdata=0 outside read data phases.
- Reset mid-transfer: everything returns to reset values immediately; queued data is lost.

Optional Feature:
MBX_IRQ_EN
- Defined: IRQ_EN register present; irq = irq_en & !rx_empty, registered (one-cycle lag after a push or pop).
- Undefined: irq tied 0; offset 0x0C is unmapped and returns ERROR.

Decomposition:
- mbx_pkg holds:
  - offset constants MBX_TXDATA/RXDATA/STATUS/IRQEN;
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR encodings;
  - HSIZE_WORD;
  - the FSM state enum typedef.
- Sub-module mbx_sync_fifo (DEPTH, DW; push/pop/full/empty/count/head), instantiated twice: TX and RX.

Test Plan:
- Write TXDATA 0xA5A5_0001, then 0x...0002, with tx_ready=0 -> both OKAY with zero wait; tx_valid=1, tx_data=0xA5A50001; STATUS read=0x0000_0202.
- Four TXDATA writes, then a fifth with tx_ready=0 -> fifth gets ERR1 (hready=0, hresp=01) then ERR2 (hready=1, hresp=01); tx_count stays 4.
- Peer pushes 0x1234 (rx_valid=1 one cycle); read RXDATA -> one wait cycle, then hrdata=0x1234 OKAY; STATUS rx_empty=1.
- Read RXDATA when empty -> two-cycle ERROR; a back-to-back NONSEQ read of STATUS in ERR2 completes OKAY.
- Byte write (hsize=000) to TXDATA, and a read of offset 0x10 -> ERROR each; no FIFO change.
- MBX_IRQ_EN defined: write IRQ_EN=1, peer push -> irq=1 one cycle later; RXDATA read -> irq=0. Undefined: write 0x0C -> ERROR, irq stays 0. Assert reset mid-RDWAIT -> hready=1, hresp=00, FIFOs empty next edge.

Source files
------------

// File: rtl/mbx_pkg.sv
// Shared constants and FSM state type for the slave-9 mailbox AHB-Lite responder.
package mbx_pkg;

   localparam logic [7:0] MBX_TXDATA = 8'h00;
   localparam logic [7:0] MBX_RXDATA = 8'h04;
   localparam logic [7:0] MBX_STATUS = 8'h08;
   localparam logic [7:0] MBX_IRQEN  = 8'h0C;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_RDWAIT,
      ST_ERR1,
      ST_ERR2
   } mbx_state_e;

endpackage

// File: rtl/mbx_sync_fifo.sv
// Single-clock FIFO with occupancy count and registered-memory head; used for the TX and RX mailbox queues.
module mbx_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DW-1:0]          wdata,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [DW-1:0]          head
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally at DEPTH; push and pop together leave count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mbx_ahb_slave.sv
// AHB-Lite mailbox target: memory-mapped TX/RX queues with two-cycle ERROR responses.
// Optional IRQ_EN register and RX-not-empty interrupt are built when MBX_IRQ_EN is defined.
module mbx_ahb_slave
   import mbx_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    hprot,
   input  logic [2:0]    hsize,
   input  logic [1:0]    htrans,
   input  logic [DW-1:0] hwdata,
   input  logic          hwrite,
   input  logic [31:0]   haddr,
   output logic [DW-1:0] hrdata,
   output logic          hready,
   output logic [1:0]    hresp,
   output logic [DW-1:0] tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   input  logic [DW-1:0] rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic          irq
);
   localparam int CW = $clog2(DEPTH) + 1;

   mbx_state_e    state;
   logic          dp_tx_push;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          tx_pop, rx_push, rx_pop;
   logic [CW-1:0] tx_count, rx_count, tx_count_nxt, rx_count_nxt;
   logic [DW-1:0] rx_head, status, rd_value;
   logic [7:0]    offset;
   logic          take, accept, mapped, tx_full_eff, addr_err;
   logic          unused_bits;

   // Peer streams: a beat transfers on a clock edge where valid and ready are both high;
   // valid never waits on ready, and ready reflects only queue space (RX) or is peer-driven (TX).
   assign tx_valid = ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_ready = ~rx_full;
   assign rx_push  = rx_valid & rx_ready;
   assign rx_pop   = (state == ST_RDWAIT);

   mbx_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(dp_tx_push), .wdata(hwdata), .pop(tx_pop),
      .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_data)
   );

   mbx_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_data), .pop(rx_pop),
      .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
   );

   assign offset      = haddr[7:0];
   assign take        = hready & htrans[1];
   // A TX push in the current data phase counts as occupancy; a same-cycle peer pop does not free space.
   assign tx_full_eff = tx_full | (dp_tx_push & (tx_count == CW'(DEPTH - 1)));
   assign addr_err    = (hsize != HSIZE_WORD) | ~mapped
                      | (hwrite & (offset == MBX_TXDATA) & tx_full_eff)
                      | (~hwrite & (offset == MBX_RXDATA) & rx_empty);
   assign accept      = take & ~addr_err;

   // STATUS is captured at the address phase but reports occupancy as seen in the data phase.
   assign tx_count_nxt = tx_count + CW'(dp_tx_push) - CW'(tx_pop);
   assign rx_count_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);

   always_comb begin
      status      = '0;
      status[3:0] = 4'(tx_count_nxt);
      status[7:4] = 4'(rx_count_nxt);
      status[8]   = (tx_count_nxt == CW'(DEPTH));
      status[9]   = (rx_count_nxt == '0);
   end

`ifdef MBX_IRQ_EN
   logic irq_en, dp_irq_wr, irq_en_nxt;

   assign mapped     = (offset == MBX_TXDATA) | (offset == MBX_RXDATA)
                     | (offset == MBX_STATUS) | (offset == MBX_IRQEN);
   assign irq_en_nxt = dp_irq_wr ? hwdata[0] : irq_en;

   always_comb begin
      rd_value = '0;
      if (offset == MBX_STATUS)     rd_value = status;
      else if (offset == MBX_IRQEN) rd_value[0] = irq_en_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en    <= 1'b0;
         dp_irq_wr <= 1'b0;
         irq       <= 1'b0;
      end else begin
         dp_irq_wr <= accept & hwrite & (offset == MBX_IRQEN);
         irq_en    <= irq_en_nxt;
         irq       <= irq_en & ~rx_empty;
      end
   end
`else
   assign mapped = (offset == MBX_TXDATA) | (offset == MBX_RXDATA) | (offset == MBX_STATUS);
   assign irq    = 1'b0;

   always_comb begin
      rd_value = '0;
      if (offset == MBX_STATUS) rd_value = status;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         hready     <= 1'b1;
         hresp      <= HRESP_OKAY;
         hrdata     <= '0;
         dp_tx_push <= 1'b0;
      end else begin
         dp_tx_push <= accept & hwrite & (offset == MBX_TXDATA);
         case (state)
            ST_RDWAIT: begin
               state  <= ST_DATA;
               hready <= 1'b1;
               hresp  <= HRESP_OKAY;
               hrdata <= rx_head;
            end
            ST_ERR1: begin
               state  <= ST_ERR2;
               hready <= 1'b1;
               hresp  <= HRESP_ERROR;
               hrdata <= '0;
            end
            default: begin
               hrdata <= '0;
               hresp  <= HRESP_OKAY;
               hready <= 1'b1;
               if (!take) begin
                  state <= ST_IDLE;
               end else if (addr_err) begin
                  state  <= ST_ERR1;
                  hready <= 1'b0;
                  hresp  <= HRESP_ERROR;
               end else if (!hwrite && (offset == MBX_RXDATA)) begin
                  state  <= ST_RDWAIT;
                  hready <= 1'b0;
               end else begin
                  state <= ST_DATA;
                  if (!hwrite) hrdata <= rd_value;
               end
            end
         endcase
      end
   end

   assign unused_bits = ^{hprot, haddr[31:8], htrans[0]};

endmodule

// File: tb/tb_mbx_ahb_slave.sv
// Self-checking bench for mbx_ahb_slave; queue-based mailbox model, follows MBX_IRQ_EN like the RTL.
module tb_mbx_ahb_slave;
   import mbx_pkg::*;

   localparam int DEPTH = 4;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    hprot = 4'h3;
   logic [2:0]    hsize = HSIZE_WORD;
   logic [1:0]    htrans = HTRANS_IDLE;
   logic [DW-1:0] hwdata = '0;
   logic          hwrite = 1'b0;
   logic [31:0]   haddr = '0;
   logic [DW-1:0] hrdata;
   logic          hready;
   logic [1:0]    hresp;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic          irq;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] tx_exp_q[$];
   logic [DW-1:0] rx_exp_q[$];
   logic          irq_en_m = 1'b0;

   always #5 clk = ~clk;

   mbx_ahb_slave #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .reset(reset), .hprot(hprot), .hsize(hsize), .htrans(htrans),
      .hwdata(hwdata), .hwrite(hwrite), .haddr(haddr), .hrdata(hrdata),
      .hready(hready), .hresp(hresp), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .irq(irq)
   );

   // ---------------- drivers and model ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s      = '0;
      s[3:0] = 4'(tx_exp_q.size());
      s[7:4] = 4'(rx_exp_q.size());
      s[8]   = (tx_exp_q.size() == DEPTH);
      s[9]   = (rx_exp_q.size() == 0);
      return s;
   endfunction

   // One non-pipelined transfer; returns final-cycle data/error, wait count and first data-cycle handshake.
   task automatic ahb_single(input logic wr, input logic [7:0] off, input logic [2:0] size,
                             input logic [31:0] wd, output logic [31:0] rd, output logic err,
                             output int waits, output logic rdy0, output logic [1:0] resp0);
      htrans = HTRANS_NONSEQ;
      hwrite = wr;
      haddr  = {24'($urandom), off};
      hsize  = size;
      hprot  = 4'($urandom);
      next_cycle();
      htrans = HTRANS_IDLE;
      hwdata = wd;
      rdy0   = hready;
      resp0  = hresp;
      waits  = 0;
      while (hready !== 1'b1 && waits < 16) begin
         waits++;
         next_cycle();
      end
      rd  = hrdata;
      err = (hresp === HRESP_ERROR);
      if (waits >= 16) begin
         n_tests++; n_fail++;
         $display("FAIL ahb_timeout: hready still %b after %0d cycles, required 1", hready, waits);
      end
      next_cycle();
   endtask

   task automatic peer_push(input logic [31:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      next_cycle();
      rx_valid = 1'b0;
   endtask

   task automatic peer_pop();
      tx_ready = 1'b1;
      next_cycle();
      tx_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] rd; logic err, r0; logic [1:0] p0; int w;
      reset = 1'b1;
      repeat (3) next_cycle();
      n_tests++; if ({hready, hresp} !== 3'b100) begin n_fail++; $display("FAIL rst_handshake: got %b required 100", {hready, hresp}); end
      n_tests++; if (hrdata !== '0) begin n_fail++; $display("FAIL rst_hrdata: got %h required 0", hrdata); end
      n_tests++; if ({tx_valid, rx_ready, irq} !== 3'b010) begin n_fail++; $display("FAIL rst_peer: got %b required 010", {tx_valid, rx_ready, irq}); end
      reset = 1'b0;
      next_cycle();
      ahb_single(1'b0, MBX_STATUS, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if ({err, w, rd} !== {1'b0, 32'd0, 32'h0000_0200}) begin n_fail++; $display("FAIL rst_status: got err=%b waits=%0d data=%h required 0/0/00000200", err, w, rd); end
   endtask

   task automatic test_tx_basic();
      logic [31:0] rd; logic err, r0; logic [1:0] p0; int w;
      tx_ready = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         ahb_single(1'b1, MBX_TXDATA, HSIZE_WORD, 32'hA5A5_0000 + i, rd, err, w, r0, p0);
         tx_exp_q.push_back(32'hA5A5_0000 + i);
         n_tests++; if ({r0, p0, err, w} !== {3'b100, 1'b0, 32'd0}) begin n_fail++; $display("FAIL tx_wr_okay: got rdy=%b resp=%b err=%b waits=%0d required 1/00/0/0", r0, p0, err, w); end
      end
      n_tests++; if ({tx_valid, tx_data} !== {1'b1, 32'hA5A5_0001}) begin n_fail++; $display("FAIL tx_head: got valid=%b data=%h required 1/a5a50001", tx_valid, tx_data); end
      ahb_single(1'b0, MBX_STATUS, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if (rd !== 32'h0000_0202) begin n_fail++; $display("FAIL tx_status: got %h required 00000202", rd); end
      ahb_single(1'b0, MBX_TXDATA, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if ({err, rd} !== 33'h0) begin n_fail++; $display("FAIL txdata_read: got err=%b data=%h required 0/0", err, rd); end
      while (tx_exp_q.size() > 0) begin
         n_tests++; if (tx_data !== tx_exp_q[0]) begin n_fail++; $display("FAIL tx_drain: got %h required %h", tx_data, tx_exp_q[0]); end
         peer_pop();
         void'(tx_exp_q.pop_front());
      end
      n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_empty: got %b required 0", tx_valid); end
   endtask

   task automatic test_back_to_back_full();
      logic [31:0] d [5]; logic [31:0] rd; logic err, r0; logic [1:0] p0; int w;
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) d[i] = $urandom;
      for (int i = 0; i < 5; i++) begin
         htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h0; hsize = HSIZE_WORD;
         next_cycle();
         hwdata = d[i];
         if (i < 4) begin
            tx_exp_q.push_back(d[i]);
            n_tests++; if ({hready, hresp} !== 3'b100) begin n_fail++; $display("FAIL b2b_wr%0d: got %b required 100", i, {hready, hresp}); end
         end else begin
            n_tests++; if ({hready, hresp} !== 3'b001) begin n_fail++; $display("FAIL full_err1: got %b required 001", {hready, hresp}); end
         end
      end
      htrans = HTRANS_IDLE;
      next_cycle();
      n_tests++; if ({hready, hresp} !== 3'b101) begin n_fail++; $display("FAIL full_err2: got %b required 101", {hready, hresp}); end
      next_cycle();
      ahb_single(1'b0, MBX_STATUS, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if (rd !== exp_status()) begin n_fail++; $display("FAIL full_status: got %h required %h", rd, exp_status()); end
      // Queue is full: a peer pop in the same cycle as the write's address phase must not rescue it.
      n_tests++; if (tx_data !== tx_exp_q[0]) begin n_fail++; $display("FAIL full_head: got %h required %h", tx_data, tx_exp_q[0]); end
      htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h0; hsize = HSIZE_WORD; tx_ready = 1'b1;
      next_cycle();
      tx_ready = 1'b0; htrans = HTRANS_IDLE; hwdata = $urandom;
      void'(tx_exp_q.pop_front());
      n_tests++; if ({hready, hresp} !== 3'b001) begin n_fail++; $display("FAIL full_pop_err1: got %b required 001", {hready, hresp}); end
      next_cycle();
      next_cycle();
      ahb_single(1'b0, MBX_STATUS, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if (rd !== exp_status()) begin n_fail++; $display("FAIL full_pop_status: got %h required %h", rd, exp_status()); end
      while (tx_exp_q.size() > 0) begin
         n_tests++; if (tx_data !== tx_exp_q[0]) begin n_fail++; $display("FAIL full_drain: got %h required %h", tx_data, tx_exp_q[0]); end
         peer_pop();
         void'(tx_exp_q.pop_front());
      end
   endtask

   task automatic test_rx_read();
      logic [31:0] rd, exp; logic err, r0; logic [1:0] p0; int w;
      peer_push(32'h0000_1234);
      rx_exp_q.push_back(32'h0000_1234);
      for (int i = 0; i < 2; i++) begin
         exp = $urandom;
         peer_push(exp);
         rx_exp_q.push_back(exp);
      end
      while (rx_exp_q.size() > 0) begin
         exp = rx_exp_q.pop_front();
         ahb_single(1'b0, MBX_RXDATA, HSIZE_WORD, '0, rd, err, w, r0, p0);
         n_tests++; if ({r0, p0, w, err} !== {3'b000, 32'd1, 1'b0}) begin n_fail++; $display("FAIL rx_wait: got rdy=%b resp=%b waits=%0d err=%b required 0/00/1/0", r0, p0, w, err); end
         n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL rx_data: got %h required %h", rd, exp); end
      end
      ahb_single(1'b0, MBX_STATUS, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if (rd !== exp_status() || rd[9] !== 1'b1) begin n_fail++; $display("FAIL rx_status: got %h required %h", rd, exp_status()); end
   endtask

   task automatic test_rx_empty_err();
      htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = {24'h0, MBX_RXDATA}; hsize = HSIZE_WORD;
      next_cycle();
      n_tests++; if ({hready, hresp, hrdata} !== {3'b001, 32'h0}) begin n_fail++; $display("FAIL rxe_err1: got %b/%h required 001/0", {hready, hresp}, hrdata); end
      haddr = {24'h0, MBX_STATUS};
      next_cycle();
      n_tests++; if ({hready, hresp} !== 3'b101) begin n_fail++; $display("FAIL rxe_err2: got %b required 101", {hready, hresp}); end
      next_cycle();
      htrans = HTRANS_IDLE;
      n_tests++; if ({hready, hresp, hrdata} !== {3'b100, exp_status()}) begin n_fail++; $display("FAIL rxe_followup: got %b/%h required 100/%h", {hready, hresp}, hrdata, exp_status()); end
      next_cycle();
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic err, r0; logic [1:0] p0; int w;
      ahb_single(1'b1, MBX_TXDATA, 3'b000, $urandom, rd, err, w, r0, p0);
      n_tests++; if ({err, r0, p0, w} !== {1'b1, 3'b001, 32'd1}) begin n_fail++; $display("FAIL byte_wr: got err=%b rdy=%b resp=%b waits=%0d required 1/0/01/1", err, r0, p0, w); end
      ahb_single(1'b0, 8'h10, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if ({err, w} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL unmapped_rd: got err=%b waits=%0d required 1/1", err, w); end
      ahb_single(1'b0, MBX_STATUS, 3'b001, '0, rd, err, w, r0, p0);
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL half_rd: got err=%b required 1", err); end
      ahb_single(1'b1, MBX_RXDATA, HSIZE_WORD, $urandom, rd, err, w, r0, p0);
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rxdata_wr: got err=%b required 0", err); end
      ahb_single(1'b1, MBX_STATUS, HSIZE_WORD, 32'hFFFF_FFFF, rd, err, w, r0, p0);
      ahb_single(1'b0, MBX_STATUS, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if ({err, rd} !== {1'b0, exp_status()}) begin n_fail++; $display("FAIL err_no_effect: got err=%b status=%h required 0/%h", err, rd, exp_status()); end
   endtask

   task automatic test_irq();
      logic [31:0] rd; logic err, r0; logic [1:0] p0; int w;
`ifdef MBX_IRQ_EN
      ahb_single(1'b1, MBX_IRQEN, HSIZE_WORD, 32'h1, rd, err, w, r0, p0);
      irq_en_m = 1'b1;
      ahb_single(1'b0, MBX_IRQEN, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if ({err, rd} !== {1'b0, 32'h1}) begin n_fail++; $display("FAIL irqen_rd: got err=%b data=%h required 0/1", err, rd); end
      peer_push(32'hCAFE_0001);
      rx_exp_q.push_back(32'hCAFE_0001);
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b required 0", irq); end
      next_cycle();
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b required 1", irq); end
      ahb_single(1'b0, MBX_RXDATA, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if ({rd, irq} !== {rx_exp_q.pop_front(), 1'b0}) begin n_fail++; $display("FAIL irq_clr: got data=%h irq=%b required cafe0001/0", rd, irq); end
`else
      ahb_single(1'b1, MBX_IRQEN, HSIZE_WORD, 32'h1, rd, err, w, r0, p0);
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL irqen_unmapped: got err=%b required 1", err); end
      peer_push(32'hCAFE_0001);
      rx_exp_q.push_back(32'hCAFE_0001);
      next_cycle();
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied: got %b required 0", irq); end
      ahb_single(1'b0, MBX_RXDATA, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if (rd !== rx_exp_q.pop_front()) begin n_fail++; $display("FAIL irq_drain: got %h required cafe0001", rd); end
`endif
   endtask

   task automatic test_random();
      logic [31:0] rd, wd, exp_rd; logic err, r0, exp_err, is_rd; logic [1:0] p0; logic [2:0] sz;
      logic [7:0] off; int w, op, exp_w;
      logic [7:0] bad_off [5];
      bad_off[0] = 8'h10; bad_off[1] = 8'h14; bad_off[2] = 8'h80; bad_off[3] = 8'hFC; bad_off[4] = 8'h02;
      for (int it = 0; it < 150; it++) begin
         op = $urandom_range(0, 9);
         if (op >= 6 && op <= 7) begin
            n_tests++; if (rx_ready !== (rx_exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_rx_ready: got %b at occupancy %0d", rx_ready, rx_exp_q.size()); end
            wd = $urandom;
            if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(wd);
            peer_push(wd);
         end else if (op == 8) begin
            n_tests++; if (tx_valid !== (tx_exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_tx_valid: got %b at occupancy %0d", tx_valid, tx_exp_q.size()); end
            if (tx_exp_q.size() > 0) begin
               n_tests++; if (tx_data !== tx_exp_q[0]) begin n_fail++; $display("FAIL rnd_tx_data: got %h required %h", tx_data, tx_exp_q[0]); end
               void'(tx_exp_q.pop_front());
            end
            peer_pop();
         end else begin
            sz = ($urandom_range(0, 7) == 0) ? 3'b001 : HSIZE_WORD;
            wd = $urandom; exp_rd = '0; is_rd = 1'b1;
            case (op)
               0, 1, 2: begin off = MBX_TXDATA; is_rd = 1'b0;
                        exp_err = (sz != HSIZE_WORD) || (tx_exp_q.size() == DEPTH); end
               3, 4:    begin off = MBX_RXDATA;
                        exp_err = (sz != HSIZE_WORD) || (rx_exp_q.size() == 0); end
               5:       begin off = MBX_STATUS; exp_err = (sz != HSIZE_WORD); exp_rd = exp_status(); end
               default: begin off = bad_off[$urandom_range(0, 4)]; is_rd = 1'($urandom); exp_err = 1'b1; end
            endcase
            if (!exp_err && op <= 2) tx_exp_q.push_back(wd);
            if (!exp_err && off == MBX_RXDATA) exp_rd = rx_exp_q.pop_front();
            exp_w = (exp_err || off == MBX_RXDATA) ? 1 : 0;
            ahb_single(~is_rd, off, sz, wd, rd, err, w, r0, p0);
            n_tests++; if ({err, w} !== {exp_err, exp_w}) begin n_fail++; $display("FAIL rnd_resp it%0d off=%h: got err=%b waits=%0d required %b/%0d", it, off, err, w, exp_err, exp_w); end
            if (is_rd && !exp_err) begin
               n_tests++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata it%0d off=%h: got %h required %h", it, off, rd, exp_rd); end
            end
            n_tests++; if (irq !== (irq_en_m && rx_exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_irq it%0d: got %b", it, irq); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic err, r0; logic [1:0] p0; int w;
      ahb_single(1'b1, MBX_TXDATA, HSIZE_WORD, 32'h5555_AAAA, rd, err, w, r0, p0);
      if (!err && tx_exp_q.size() < DEPTH) tx_exp_q.push_back(32'h5555_AAAA);
      peer_push(32'h0BAD_F00D);
      htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = {24'h0, MBX_RXDATA}; hsize = HSIZE_WORD;
      next_cycle();
      htrans = HTRANS_IDLE;
      n_tests++; if (hready !== 1'b0) begin n_fail++; $display("FAIL mid_rdwait: got hready=%b required 0", hready); end
      #2 reset = 1'b1;
      #1;
      n_tests++; if ({hready, hresp, hrdata, tx_valid, rx_ready, irq} !== {3'b100, 32'h0, 3'b010}) begin n_fail++; $display("FAIL mid_reset: got rdy=%b resp=%b data=%h txv=%b rxr=%b irq=%b", hready, hresp, hrdata, tx_valid, rx_ready, irq); end
      tx_exp_q.delete(); rx_exp_q.delete(); irq_en_m = 1'b0;
      next_cycle();
      reset = 1'b0;
      next_cycle();
      ahb_single(1'b0, MBX_STATUS, HSIZE_WORD, '0, rd, err, w, r0, p0);
      n_tests++; if (rd !== 32'h0000_0200) begin n_fail++; $display("FAIL mid_status: got %h required 00000200", rd); end
   endtask

   initial begin
      test_reset();
      test_tx_basic();
      test_back_to_back_full();
      test_rx_read();
      test_rx_empty_err();
      test_errors();
      test_irq();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
